// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: debouncer FSM state type, 50 MHz default timing constants and counter width helper
package sw_debounce_pkg;
  typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} sw_state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep reset-to-0 synchroniser for an asynchronous input pin
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer: synchronised, debounced switch level with edge strobes; SW_AUTOREPEAT_EN adds held-switch step repeat
module sw_debouncer
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic step
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sw_s, done, hit;
  sw_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(sw_raw), .q(sw_s));
  always_comb begin
    done = cnt_q == DB_LAST;
    state_d = state_q;
    case (state_q)
      STABLE_LOW:  state_d = sw_s ? WAIT_HIGH : STABLE_LOW;
      WAIT_HIGH:   state_d = !sw_s ? STABLE_LOW : done ? STABLE_HIGH : WAIT_HIGH;
      STABLE_HIGH: state_d = !sw_s ? WAIT_LOW : STABLE_HIGH;
      default:     state_d = sw_s ? STABLE_HIGH : done ? STABLE_LOW : WAIT_LOW;
    endcase
    // any state change or repeat strobe restarts the shared counter from 0
    cnt_d = (state_d != state_q || hit) ? '0 : &cnt_q ? cnt_q : cnt_q + 1'b1;
    level_d = state_d == STABLE_HIGH || state_d == WAIT_LOW;
    rise_d = state_q == WAIT_HIGH && state_d == STABLE_HIGH;
    fall_d = state_q == WAIT_LOW && state_d == STABLE_LOW;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= STABLE_LOW;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  assign sw_level = level_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
`ifdef SW_AUTOREPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  logic rep_q, rep_d, step_q, step_d;
  always_comb begin
    hit = state_q == STABLE_HIGH && state_d == STABLE_HIGH && cnt_q == (rep_q ? PERIOD_LAST : DELAY_LAST);
    // a bounce back from WAIT_LOW resumes in the periodic phase
    rep_d = rise_d ? 1'b0 : (hit || (state_q == WAIT_LOW && state_d == STABLE_HIGH)) ? 1'b1 : rep_q;
    step_d = rise_d || hit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rep_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      step_q <= step_d;
    end
  assign step = step_q;
`else
  assign hit = 1'b0;
  assign step = rise_q;
`endif
endmodule

// File: doc/sw_debouncer.md
# sw_debouncer

Front-end conditioning stage for the board slide switch: synchronises the asynchronous `sw_raw` pin into the `clk` domain, rejects contact bounce, and presents a clean level plus single-cycle edge strobes. Sits directly upstream of the up/down LED counter. `sw_level` drives the counter's direction input and `step` drives its count-enable. An optional auto-repeat turns a held switch into a periodic step stream.

## Interface
- `SYNC_STAGES`, 2 — synchroniser flop depth; legal values are 2 or more.
- `DEBOUNCE_CYCLES`, 50000 — consecutive stable synchronised samples required to accept a new level (1 ms at 50 MHz); legal values are 1 or more.
- `REPEAT_DELAY`, 25000000 — cycles from an accepted rise to the first repeat step (auto-repeat builds only).
- `REPEAT_PERIOD`, 5000000 — cycles between subsequent repeat steps (auto-repeat builds only); legal values are 1 or more.
- `clk`  in  1  — single system clock; all logic is on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `sw_raw`  in  1  — raw switch pin; asynchronous and bouncy.
- `sw_level`  out  1  — debounced switch level.
- `sw_rise`  out  1  — one-cycle pulse in the cycle `sw_level` goes 0→1.
- `sw_fall`  out  1  — one-cycle pulse in the cycle `sw_level` goes 1→0.
- `step`  out  1  — one-cycle count-enable strobe for the downstream counter.

## Operation
- Synchroniser: chain of `SYNC_STAGES` flops, all reset to 0. Its last stage is `sw_s`.
- FSM states:
  - STABLE_LOW: `sw_s`=1 → go to WAIT_HIGH, clear the counter.
  - WAIT_HIGH: `sw_s`=0 → back to STABLE_LOW. Counter reaching `DEBOUNCE_CYCLES`−1 while `sw_s`=1 → STABLE_HIGH.
  - STABLE_HIGH: `sw_s`=0 → go to WAIT_LOW, clear the counter.
  - WAIT_LOW: `sw_s`=1 → back to STABLE_HIGH. Counter reaching `DEBOUNCE_CYCLES`−1 while `sw_s`=0 → STABLE_LOW.
- Any mismatch during a WAIT state aborts the wait. No edge pulse is produced and the counter restarts from 0 on the next qualifying sample.
- Counter:
  - Width is `$clog2` of the largest of `DEBOUNCE_CYCLES`, `REPEAT_DELAY` and `REPEAT_PERIOD`, plus 1.
  - It saturates and never wraps.
  - It is shared between the debounce and repeat functions, which are never active at the same time.
- `sw_level` is 1 in STABLE_HIGH and WAIT_LOW, and 0 otherwise. It is a registered output.
- Edge strobes:
  - `sw_rise` pulses in the same cycle as the WAIT_HIGH→STABLE_HIGH transition becomes visible on `sw_level`.
  - `sw_fall` pulses likewise for WAIT_LOW→STABLE_LOW.
  - Both are registered. They are never high together and never high for two consecutive cycles.
- Reset behaviour:
  - All outputs are 0, the FSM is in STABLE_LOW, and the counter is 0.
  - If `sw_raw` is already high at reset release, the normal debounce runs and produces exactly one `sw_rise`.
  - Reset asserted mid-wait discards the pending transition with no pulse.

## Timing
- Latency from a clean `sw_raw` transition (first sampled at edge k) to the `sw_level` change and edge pulse is edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised samples never reach `sw_level`.
- `step` has no handshake. The consumer samples it every cycle, and each high cycle is exactly one count.

## Configuration
- `SW_AUTOREPEAT_EN` defined:
  - `step` pulses with `sw_rise`.
  - While the FSM stays in STABLE_HIGH, `step` also pulses `REPEAT_DELAY` cycles after that rise, then every `REPEAT_PERIOD` cycles after.
  - The repeat stops the cycle the FSM leaves STABLE_HIGH, including entry to WAIT_LOW. A return from WAIT_LOW restarts the `REPEAT_PERIOD` spacing from 0.
- `SW_AUTOREPEAT_EN` undefined: `step` is identical to `sw_rise`. The `REPEAT_*` parameters are ignored and no repeat logic is synthesised.

## Structure
- Package `sw_debounce_pkg` holds:
  - the FSM state typedef (STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW);
  - the default constants for `DEBOUNCE_CYCLES`, `REPEAT_DELAY` and `REPEAT_PERIOD` at 50 MHz.
- One sub-module, `sync_ff`: a parameterised `SYNC_STAGES` bit synchroniser with async active-low reset. It is reusable by other pin inputs.

## Test plan
Bench parameters for all cases: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- **Clean press:** `sw_raw` goes 0→1 at edge 10 and is held → `sw_level`=1 and `sw_rise`=1 at edge 16 only, `sw_fall` stays 0, `step` pulses at edge 16.
- **Bounce:** `sw_raw` toggles 1,0,1,0 every 2 cycles, then is held 1 → no pulse during bouncing, exactly one `sw_rise` 6 cycles after the final rising edge.
- **Release glitch:** while high, `sw_raw`=0 for 3 cycles → `sw_level` stays 1 and no `sw_fall`. A 0 held for 8 cycles → one `sw_fall`, with `sw_level`=0 from edge start+6.
- **Reset mid-wait:** `rst_n` asserted 2 cycles into WAIT_HIGH → all outputs 0 immediately. After release with `sw_raw`=1 → a single `sw_rise` 6 cycles after the first sampling edge.
- **Auto-repeat (`SW_AUTOREPEAT_EN`):** hold the switch → `step` at rise edge R, then R+10, R+13, R+16…. Release → no `step` after WAIT_LOW is entered.
- **No macro:** the same hold gives one `step` at R only, and `step` equals `sw_rise` on every cycle.
